// File: rtl/clock_div_gen_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The config check is kept here so every channel judges div/high identically.
package clock_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } chan_state_t;

    localparam int MIN_DIV = 2;

    // Callers zero-extend their CW-bit fields, so all compares stay unsigned.
    function automatic logic cfg_valid(input logic [31:0] div, input logic [31:0] high);
        return (div >= 32'(MIN_DIV)) && (high != 32'd0) && (high < div);
    endfunction

endpackage

// File: rtl/clock_div_gen_if.sv
// Config/status bundle for clock_div_gen; channel i owns bits [i*CW +: CW].
interface clock_div_gen_if #(
    parameter int NCH = 2,
    parameter int CW  = 16
);
    logic [NCH-1:0]    enable;
    logic [NCH*CW-1:0] div;
    logic [NCH*CW-1:0] high;
    logic [NCH*CW-1:0] phase;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    rise_tick;
    logic [NCH-1:0]    fall_tick;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    cfg_err;

    modport master (
        output enable, div, high, phase,
        input  clk_out, rise_tick, fall_tick, busy, cfg_err
    );

    modport slave (
        input  enable, div, high, phase,
        output clk_out, rise_tick, fall_tick, busy, cfg_err
    );
endinterface

// File: rtl/clock_div_gen_chan.sv
// One divider channel: IDLE/DELAY/RUN FSM with shadow config that is only
// reloaded at period boundaries, so clk_out never produces a runt pulse.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [CW-1:0] div,
    input  logic [CW-1:0] high,
    input  logic [CW-1:0] phase,
    output logic          clk_out,
    output logic          rise_tick,
    output logic          fall_tick,
    output logic          busy,
    output logic          cfg_err
);

    chan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] dcnt, dcnt_n;
    logic [CW-1:0] sdiv, sdiv_n;
    logic [CW-1:0] shigh, shigh_n;
    logic          err_n, cfg_ok;
    logic          clk_n, rise_n, fall_n, busy_n;

    assign cfg_ok = cfg_valid(32'(div), 32'(high));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            sdiv      <= '0;
            shigh     <= '0;
            cfg_err   <= 1'b0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dcnt      <= dcnt_n;
            sdiv      <= sdiv_n;
            shigh     <= shigh_n;
            cfg_err   <= err_n;
            clk_out   <= clk_n;
            rise_tick <= rise_n;
            fall_tick <= fall_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dcnt_n  = dcnt;
        sdiv_n  = sdiv;
        shigh_n = shigh;
        err_n   = cfg_err;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    if (cfg_ok) begin
                        sdiv_n  = div;
                        shigh_n = high;
                        err_n   = 1'b0;
                        if (phase == '0) begin
                            state_n = RUN;
                        end else begin
                            state_n = DELAY;
                            dcnt_n  = phase - CW'(1);
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (dcnt == '0) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    dcnt_n = dcnt - CW'(1);
                end
            end
            RUN: begin
                // enable is only honoured at the boundary so the period always completes
                if (cnt == sdiv - CW'(1)) begin
                    cnt_n = '0;
                    if (!enable) begin
                        state_n = IDLE;
                    end else if (cfg_ok) begin
                        sdiv_n  = div;
                        shigh_n = high;
                        err_n   = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the counter value they describe.
    always_comb begin
        clk_n  = (state_n == RUN) && (cnt_n < shigh_n);
        rise_n = (state_n == RUN) && (cnt_n == '0);
        fall_n = (state_n == RUN) && (cnt_n == shigh_n);
        busy_n = (state_n != IDLE);
    end

endmodule

// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock generator: NCH independent divider channels
// sharing the system clock, configured through packed per-channel buses.
module clock_div_gen
    import clock_div_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    clock_div_gen_if.slave  bus
);

    logic [NCH-1:0] clk_out_w;
    logic [NCH-1:0] rise_w;
    logic [NCH-1:0] fall_w;
    logic [NCH-1:0] busy_w;
    logic [NCH-1:0] err_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clock_div_chan #(.CW(CW)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .enable    (bus.enable[i]),
            .div       (bus.div[i*CW +: CW]),
            .high      (bus.high[i*CW +: CW]),
            .phase     (bus.phase[i*CW +: CW]),
            .clk_out   (clk_out_w[i]),
            .rise_tick (rise_w[i]),
            .fall_tick (fall_w[i]),
            .busy      (busy_w[i]),
            .cfg_err   (err_w[i])
        );
    end

    assign bus.clk_out   = clk_out_w;
    assign bus.rise_tick = rise_w;
    assign bus.fall_tick = fall_w;
    assign bus.busy      = busy_w;
    assign bus.cfg_err   = err_w;

endmodule

// File: doc/clock_div_gen.md
Name: clock_div_gen

Overview:
- Synthesizable, multi-channel, programmable clock generator driven from the single system clock.
- Each channel produces a divided clock-like output with programmable period, high time, start phase and enable, plus single-cycle rise/fall tick enables.
- Intended for the VGA path and its testbenches, e.g. pixel-rate enables and phase-shifted strobes, replacing delay-based generation with cycle-exact logic.
- Config changes take effect only at period boundaries, so outputs never glitch.

Parameters:
- NCH, 2, number of independent channels.
- CW, 16, width of the div/high/phase counters and config fields.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  NCH  per-channel run request.
- div  in  NCH*CW  per-channel period in clk cycles; channel i uses bits [i*CW +: CW]; valid 2..2^CW-1.
- high  in  NCH*CW  per-channel high time in cycles; valid 1..div-1.
- phase  in  NCH*CW  per-channel start delay in cycles; 0..2^CW-1.
- clk_out  out  NCH  registered divided output.
- rise_tick  out  NCH  1-cycle pulse in the first high cycle of each period.
- fall_tick  out  NCH  1-cycle pulse in the first low cycle of each period.
- busy  out  NCH  channel not IDLE.
- cfg_err  out  NCH  sticky: last sampled config was invalid.

Behaviour:
- Reset: all outputs 0, every channel IDLE, counters 0, shadow config 0. Reset overrides everything, including mid-period; clk_out is 0 in the cycle after rst is sampled.
- Per-channel FSM states: IDLE, DELAY, RUN. Channels are fully independent.
- IDLE
  - clk_out = 0.
  - When enable is sampled 1, sample div/high/phase.
  - Invalid config (div<2, high==0, or high>=div): set cfg_err, stay IDLE, and retry every cycle while enable=1.
  - Valid config: latch into shadow registers and clear cfg_err.
  - phase==0: go to RUN with cnt=0.
  - phase>0: go to DELAY with dcnt=phase-1.
- Latency:
  - phase=0: clk_out is first high in the cycle after the edge that first samples enable=1.
  - Otherwise clk_out is first high exactly phase cycles later.
- DELAY
  - dcnt decrements each cycle; at dcnt==0 go to RUN with cnt=0.
  - enable=0 in DELAY: abort to IDLE immediately, no pulse emitted.
- RUN
  - cnt counts 0..div-1 and wraps.
  - clk_out = 1 when cnt<high, else 0.
  - rise_tick = 1 when cnt==0; fall_tick = 1 when cnt==high. Both are registered together with clk_out.
  - At cnt==div-1 with enable=1:
    - Resample the config ports.
    - Valid: load it for the next period.
    - Invalid: keep the old shadow config and set cfg_err.
    - Phase is ignored on reload; period boundaries are contiguous.
  - At cnt==div-1 with enable=0: go to IDLE. busy is 0 in the following cycle.
- enable dropped mid-period in RUN: the current period completes in full; no runt high or low pulse is ever produced.
- enable re-raised before the period ends: the channel simply continues.
- Config ports changing mid-period have no effect until the boundary.
- Arithmetic: all compares are unsigned CW-bit; counters never exceed div-1, so there is no overflow.

Decomposition:
- Package clock_div_pkg:
  - typedef enum logic [1:0] {IDLE, DELAY, RUN} chan_state_t.
  - localparam MIN_DIV = 2.
  - function cfg_valid(div, high).
- Sub-module clock_div_chan: one channel (FSM, counters, shadow config).
- Top clock_div_gen instantiates NCH copies via generate and slices the packed config buses.

Test Plan:
- Reset: div=4, high=2, phase=0, enable=1 with rst held 5 cycles -> all outputs 0. After release -> clk_out=1,1,0,0 repeating from the cycle after the first sampled enable, rise_tick on each cnt=0.
- Phase: both channels div=8, high=4; ch0 phase=0, ch1 phase=3, enables rise together -> ch1 clk_out and rise_tick lag ch0 by exactly 3 cycles, every period.
- Duty extremes: div=5, high=1 -> 1,0,0,0,0 repeating, fall_tick at cnt=1. div=2, high=1 -> alternating 1,0.
- Clean stop: div=6, high=3, enable dropped at cnt=1 -> pattern completes 1,1,1,0,0,0, then clk_out=0 and busy=0 from the next cycle. Drop enable during DELAY -> no pulse at all.
- Config error: high=div=4 -> cfg_err=1, clk_out stays 0, busy=0. Change to high=2 -> cfg_err clears and the channel starts.
- Runtime reload and mid-run reset:
  - Running div=4, high=2; change to div=6, high=3 at cnt=1 -> current period lasts 4 cycles, next period 6 cycles with high=3.
  - Invalid mid-run update -> old 4/2 pattern continues and cfg_err=1.
  - Assert rst mid-period -> all outputs 0 the next cycle.
